// File: rtl/axi_burst_master_if.sv
// Command, write-stream, read-stream, completion and AXI4 channel signals of the burst master.
// Every valid/ready pair transfers one item on a rising clock edge where both are high; a
// producer holds valid and payload stable until that edge, and ready may change freely.
interface axi_burst_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic [1:0]        cmd_burst;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid, wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, rd_last, rd_ready;
  logic              done, done_err;
  logic [1:0]        done_resp;

  logic [ADDR_W-1:0] awaddr, araddr;
  logic [7:0]        awlen, arlen;
  logic [2:0]        awsize, arsize;
  logic [1:0]        awburst, arburst;
  logic              awvalid, awready, arvalid, arready;
  logic [DATA_W-1:0] wdata, rdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              wlast, wvalid, wready;
  logic [1:0]        bresp, rresp;
  logic              bvalid, bready;
  logic              rlast, rvalid, rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_burst, wr_data, wr_valid, rd_ready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid,
    output cmd_ready, wr_ready, rd_data, rd_valid, rd_last, done, done_resp, done_err,
    output awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output araddr, arlen, arsize, arburst, arvalid, rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_burst, wr_data, wr_valid, rd_ready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid,
    input  cmd_ready, wr_ready, rd_data, rd_valid, rd_last, done, done_resp, done_err,
    input  awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  araddr, arlen, arsize, arburst, arvalid, rready
  );
endinterface

// File: rtl/axi_burst_master.sv
// AXI4 burst master: takes one checked read/write command at a time, runs it as a single
// FIXED/INCR/WRAP burst and reports completion with a worst-case response and error flag.
module axi_burst_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_LEN = 16
) (
  input  logic               aclk,
  input  logic               areset,
  axi_burst_master_if.master bus,
  output logic [2:0]         dbg_state
);
  localparam int                BYTES      = DATA_W / 8;
  localparam logic [2:0]        AXSIZE     = 3'($clog2(BYTES));
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_AW, S_WDATA, S_WRESP, S_AR, S_RDATA, S_DONE
  } state_t;

  state_t            state;
  logic              c_write;
  logic [ADDR_W-1:0] c_addr;
  logic [7:0]        c_len;
  logic [1:0]        c_burst;
  logic [7:0]        beat_cnt;
  logic [1:0]        resp_acc;
  logic              rlast_err;
  logic [13:0]       incr_end;
  logic              reject;
  logic              last_beat;

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Legality of the registered command; incr_end is the byte offset just past the burst.
  always_comb begin
    incr_end = 14'(c_addr[11:0]) + (14'(c_len) + 14'd1) * 14'(BYTES);
    reject   = 1'b0;
    if (c_burst == 2'b11) reject = 1'b1;
    if (9'(c_len) >= 9'(MAX_LEN)) reject = 1'b1;
    if ((c_addr & ALIGN_MASK) != '0) reject = 1'b1;
    if (c_burst == 2'b10 && !(c_len inside {8'd1, 8'd3, 8'd7, 8'd15})) reject = 1'b1;
    if (c_burst == 2'b01 && incr_end > 14'd4096) reject = 1'b1;
  end

  assign last_beat     = (beat_cnt == c_len);
  assign dbg_state     = state;
  assign bus.cmd_ready = (state == S_IDLE);

  // Data beats pass straight through; the FSM only gates them and counts.
  assign bus.wvalid   = (state == S_WDATA) && bus.wr_valid;
  assign bus.wr_ready = (state == S_WDATA) && bus.wready;
  assign bus.wdata    = bus.wr_data;
  assign bus.wstrb    = '1;
  assign bus.wlast    = (state == S_WDATA) && last_beat;
  assign bus.rready   = (state == S_RDATA) && bus.rd_ready;
  assign bus.rd_valid = (state == S_RDATA) && bus.rvalid;
  assign bus.rd_data  = bus.rdata;
  assign bus.rd_last  = (state == S_RDATA) && last_beat;
  assign bus.awsize   = AXSIZE;
  assign bus.arsize   = AXSIZE;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= S_IDLE;
      c_write       <= 1'b0;
      c_addr        <= '0;
      c_len         <= '0;
      c_burst       <= '0;
      beat_cnt      <= '0;
      resp_acc      <= '0;
      rlast_err     <= 1'b0;
      bus.awvalid   <= 1'b0;
      bus.awaddr    <= '0;
      bus.awlen     <= '0;
      bus.awburst   <= '0;
      bus.arvalid   <= 1'b0;
      bus.araddr    <= '0;
      bus.arlen     <= '0;
      bus.arburst   <= '0;
      bus.bready    <= 1'b0;
      bus.done      <= 1'b0;
      bus.done_resp <= 2'b00;
      bus.done_err  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: if (bus.cmd_valid) begin
          c_write <= bus.cmd_write;
          c_addr  <= bus.cmd_addr;
          c_len   <= bus.cmd_len;
          c_burst <= bus.cmd_burst;
          state   <= S_CHECK;
        end
        S_CHECK: begin
          beat_cnt  <= '0;
          resp_acc  <= 2'b00;
          rlast_err <= 1'b0;
          if (reject) begin
            bus.done      <= 1'b1;
            bus.done_resp <= 2'b10;
            bus.done_err  <= 1'b1;
            state         <= S_DONE;
          end else if (c_write) begin
            bus.awaddr  <= c_addr;
            bus.awlen   <= c_len;
            bus.awburst <= c_burst;
            bus.awvalid <= 1'b1;
            state       <= S_AW;
          end else begin
            bus.araddr  <= c_addr;
            bus.arlen   <= c_len;
            bus.arburst <= c_burst;
            bus.arvalid <= 1'b1;
            state       <= S_AR;
          end
        end
        S_AW: if (bus.awready) begin
          bus.awvalid <= 1'b0;
          state       <= S_WDATA;
        end
        S_WDATA: if (bus.wr_valid && bus.wready) begin
          if (last_beat) begin
            bus.bready <= 1'b1;
            state      <= S_WRESP;
          end else begin
            beat_cnt <= beat_cnt + 8'd1;
          end
        end
        S_WRESP: if (bus.bvalid) begin
          bus.bready    <= 1'b0;
          bus.done      <= 1'b1;
          bus.done_resp <= bus.bresp;
          bus.done_err  <= 1'b0;
          state         <= S_DONE;
        end
        S_AR: if (bus.arready) begin
          bus.arvalid <= 1'b0;
          state       <= S_RDATA;
        end
        // Exactly len+1 beats are consumed regardless of where the slave puts rlast.
        S_RDATA: if (bus.rvalid && bus.rd_ready) begin
          if (last_beat) begin
            bus.done <= 1'b1;
            if (rlast_err || !bus.rlast) begin
              bus.done_resp <= 2'b10;
              bus.done_err  <= 1'b1;
            end else begin
              bus.done_resp <= worst(resp_acc, bus.rresp);
              bus.done_err  <= 1'b0;
            end
            state <= S_DONE;
          end else begin
            beat_cnt <= beat_cnt + 8'd1;
            resp_acc <= worst(resp_acc, bus.rresp);
            if (bus.rlast) rlast_err <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: reactive AXI slave and stream endpoints, with
// expected-value queues checked by negedge monitors as the DUT presents each transfer.
`timescale 1ns/1ps
module tb_axi_burst_master;
  localparam int ADDR_W = 32, DATA_W = 32, MAX_LEN = 16;

  logic       aclk = 1'b0;
  logic       areset = 1'b1;
  logic [2:0] dbg_state;

  axi_burst_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LEN(MAX_LEN)) dut (
    .aclk(aclk), .areset(areset), .bus(bus), .dbg_state(dbg_state)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_fail = 0;
  logic [63:0] exp_aw_q[$], exp_ar_q[$], exp_w_q[$], exp_rd_q[$], exp_done_q[$];
  logic [31:0] wr_src_q[$];

  logic        cfg_wready_toggle = 1'b0, cfg_wr_gap = 1'b0, cfg_rd_half = 1'b0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp_val = 2'b00;
  int          cfg_rlast_beat = -1, cfg_rresp_beat = -1;
  logic [31:0] cfg_r_base = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name, inout logic [63:0] q[$], input logic [63:0] act);
    if (q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: unexpected transfer %0h, nothing expected", name, act);
    end else begin
      check(name, act, q.pop_front());
    end
  endtask

  function automatic logic [63:0] pack_ax(input logic [31:0] a, input logic [7:0] l,
                                          input logic [1:0] b, input logic [2:0] s);
    return {19'd0, a, l, b, s};
  endfunction
  function automatic logic [63:0] pack_w(input logic [3:0] strb, input logic last, input logic [31:0] d);
    return {27'd0, strb, last, d};
  endfunction
  function automatic logic [63:0] pack_rd(input logic last, input logic [31:0] d);
    return {31'd0, last, d};
  endfunction
  function automatic logic [63:0] pack_done(input logic [1:0] resp, input logic err);
    return {61'd0, resp, err};
  endfunction

  // Scoreboard monitors
  always @(negedge aclk) begin
    if (!areset) begin
      if (bus.awvalid && bus.awready)
        pop_check("aw", exp_aw_q, pack_ax(bus.awaddr, bus.awlen, bus.awburst, bus.awsize));
      if (bus.arvalid && bus.arready)
        pop_check("ar", exp_ar_q, pack_ax(bus.araddr, bus.arlen, bus.arburst, bus.arsize));
      if (bus.wvalid && bus.wready)
        pop_check("w_beat", exp_w_q, pack_w(bus.wstrb, bus.wlast, bus.wdata));
      if (bus.rd_valid && bus.rd_ready)
        pop_check("rd_beat", exp_rd_q, pack_rd(bus.rd_last, bus.rd_data));
      if (bus.done)
        pop_check("done", exp_done_q, pack_done(bus.done_resp, bus.done_err));
    end
  end

  // Slave and stream endpoints: sample at negedge, update drives just after posedge.
  initial begin : env
    logic w_hs, w_last_hs, b_hs, ar_hs, r_hs, rst_s;
    logic [7:0] ar_len_s;
    int cyc, r_idx, r_len;
    cyc = 0; r_idx = 0; r_len = 0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
    bus.awready = 1'b1; bus.arready = 1'b1; bus.wready = 1'b1;
    bus.bvalid = 1'b0; bus.bresp = 2'b00;
    bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00; bus.rlast = 1'b0;
    forever begin
      @(negedge aclk);
      w_hs      = bus.wr_valid && bus.wr_ready;
      w_last_hs = w_hs && bus.wlast;
      b_hs      = bus.bvalid && bus.bready;
      ar_hs     = bus.arvalid && bus.arready;
      ar_len_s  = bus.arlen;
      r_hs      = bus.rvalid && bus.rready;
      rst_s     = areset;
      @(posedge aclk);
      #1;
      cyc++;
      if (rst_s) begin
        wr_src_q.delete();
        bus.wr_valid = 1'b0;
        bus.bvalid   = 1'b0;
        bus.rvalid   = 1'b0;
        r_len = 0;
        r_idx = 0;
      end else begin
        if (w_hs) void'(wr_src_q.pop_front());
        if (!(bus.wr_valid && !w_hs))
          bus.wr_valid = (wr_src_q.size() > 0) && !(cfg_wr_gap && (cyc % 3 == 0));
        bus.wr_data = (wr_src_q.size() > 0) ? wr_src_q[0] : 32'h0;
        bus.wready  = cfg_wready_toggle ? (cyc % 2 == 1) : 1'b1;
        if (b_hs) bus.bvalid = 1'b0;
        if (w_last_hs) begin
          bus.bvalid = 1'b1;
          bus.bresp  = cfg_bresp;
        end
        if (r_hs) r_idx++;
        if (ar_hs) begin
          r_len = int'(ar_len_s) + 1;
          r_idx = 0;
        end
        bus.rvalid   = (r_idx < r_len);
        bus.rdata    = cfg_r_base + 32'(r_idx);
        bus.rlast    = (cfg_rlast_beat >= 0) ? (r_idx == cfg_rlast_beat) : (r_idx == r_len - 1);
        bus.rresp    = (r_idx == cfg_rresp_beat) ? cfg_rresp_val : 2'b00;
        bus.rd_ready = cfg_rd_half ? (cyc % 2 == 0) : 1'b1;
      end
    end
  end

  task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [7:0] l, input logic [1:0] b);
    bit hs = 0;
    @(posedge aclk);
    #1;
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_len = l; bus.cmd_burst = b;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge aclk);
      hs = bus.cmd_ready;
      @(posedge aclk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    if (!hs) begin
      n_cmp++;
      n_fail++;
      $display("FAIL cmd_accept: got cmd_ready 0 for 100 cycles expected 1");
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_done_q.size() + exp_w_q.size() + exp_rd_q.size() + exp_aw_q.size() + exp_ar_q.size()) != 0
           && n < 300) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 300) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending expectations expected 0",
               name, exp_done_q.size() + exp_w_q.size() + exp_rd_q.size());
      exp_done_q.delete(); exp_w_q.delete(); exp_rd_q.delete(); exp_aw_q.delete(); exp_ar_q.delete();
    end
    repeat (2) @(negedge aclk);
  endtask

  initial begin : main
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.cmd_burst = '0;
    areset = 1'b1;
    repeat (2) @(negedge aclk);
    check("reset_valids", 64'({bus.awvalid, bus.arvalid, bus.wvalid, bus.bready, bus.rready,
                               bus.rd_valid, bus.wr_ready, bus.done, bus.done_err}), 64'd0);
    check("reset_done_resp", 64'(bus.done_resp), 64'd0);
    check("reset_ax_regs", 64'({bus.awaddr, bus.awlen}) | 64'({bus.araddr, bus.arlen}), 64'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    check("cmd_ready_after_reset", 64'(bus.cmd_ready), 64'd1);

    // 1: write INCR 0x100 len 3, data 1..4, plus command-to-AWVALID latency
    exp_aw_q.push_back(pack_ax(32'h100, 8'd3, 2'b01, 3'd2));
    for (int i = 1; i <= 4; i++) begin
      wr_src_q.push_back(32'(i));
      exp_w_q.push_back(pack_w(4'hF, i == 4, 32'(i)));
    end
    exp_done_q.push_back(pack_done(2'b00, 1'b0));
    send_cmd(1'b1, 32'h100, 8'd3, 2'b01);
    @(negedge aclk);
    check("t1_awvalid_T+1", 64'(bus.awvalid), 64'd0);
    @(negedge aclk);
    check("t1_awvalid_T+2", 64'(bus.awvalid), 64'd1);
    wait_idle("t1");

    // 2: read WRAP 0x10C len 3
    cfg_r_base = 32'hA0;
    exp_ar_q.push_back(pack_ax(32'h10C, 8'd3, 2'b10, 3'd2));
    exp_rd_q.push_back(pack_rd(1'b0, 32'hA0));
    exp_rd_q.push_back(pack_rd(1'b0, 32'hA1));
    exp_rd_q.push_back(pack_rd(1'b0, 32'hA2));
    exp_rd_q.push_back(pack_rd(1'b1, 32'hA3));
    exp_done_q.push_back(pack_done(2'b00, 1'b0));
    send_cmd(1'b0, 32'h10C, 8'd3, 2'b10);
    wait_idle("t2");

    // 3: len 7 write with wready toggling and source gaps, then len 7 read at half rate
    cfg_wready_toggle = 1'b1; cfg_wr_gap = 1'b1; cfg_rd_half = 1'b1; cfg_r_base = 32'h50;
    exp_aw_q.push_back(pack_ax(32'h200, 8'd7, 2'b01, 3'd2));
    for (int i = 0; i < 8; i++) begin
      wr_src_q.push_back(32'h30 + 32'(i));
      exp_w_q.push_back(pack_w(4'hF, i == 7, 32'h30 + 32'(i)));
    end
    exp_done_q.push_back(pack_done(2'b00, 1'b0));
    send_cmd(1'b1, 32'h200, 8'd7, 2'b01);
    wait_idle("t3_write");
    exp_ar_q.push_back(pack_ax(32'h300, 8'd7, 2'b01, 3'd2));
    for (int i = 0; i < 8; i++) exp_rd_q.push_back(pack_rd(i == 7, 32'h50 + 32'(i)));
    exp_done_q.push_back(pack_done(2'b00, 1'b0));
    send_cmd(1'b0, 32'h300, 8'd7, 2'b01);
    wait_idle("t3_read");
    cfg_wready_toggle = 1'b0; cfg_wr_gap = 1'b0; cfg_rd_half = 1'b0;

    // INCR ending exactly on the 4KB boundary is legal; BRESP 11 propagates
    cfg_bresp = 2'b11;
    exp_aw_q.push_back(pack_ax(32'hFF0, 8'd3, 2'b01, 3'd2));
    for (int i = 0; i < 4; i++) begin
      wr_src_q.push_back(32'hC0 + 32'(i));
      exp_w_q.push_back(pack_w(4'hF, i == 3, 32'hC0 + 32'(i)));
    end
    exp_done_q.push_back(pack_done(2'b11, 1'b0));
    send_cmd(1'b1, 32'hFF0, 8'd3, 2'b01);
    wait_idle("t4k_edge");
    cfg_bresp = 2'b00;

    // 4: rejected commands, no AXI traffic expected
    exp_done_q.push_back(pack_done(2'b10, 1'b1));
    send_cmd(1'b1, 32'hFF8, 8'd3, 2'b01);
    wait_idle("rej_4k");
    exp_done_q.push_back(pack_done(2'b10, 1'b1));
    send_cmd(1'b0, 32'h102, 8'd0, 2'b01);
    wait_idle("rej_align");
    exp_done_q.push_back(pack_done(2'b10, 1'b1));
    send_cmd(1'b1, 32'h0, 8'd0, 2'b11);
    wait_idle("rej_burst11");
    exp_done_q.push_back(pack_done(2'b10, 1'b1));
    send_cmd(1'b0, 32'h40, 8'd2, 2'b10);
    wait_idle("rej_wrap_len");
    exp_done_q.push_back(pack_done(2'b10, 1'b1));
    send_cmd(1'b0, 32'h40, 8'd16, 2'b01);
    wait_idle("rej_max_len");

    // 5a: early rlast on beat 2, still 4 beats consumed
    cfg_rlast_beat = 1; cfg_r_base = 32'h70;
    exp_ar_q.push_back(pack_ax(32'h400, 8'd3, 2'b01, 3'd2));
    for (int i = 0; i < 4; i++) exp_rd_q.push_back(pack_rd(i == 3, 32'h70 + 32'(i)));
    exp_done_q.push_back(pack_done(2'b10, 1'b1));
    send_cmd(1'b0, 32'h400, 8'd3, 2'b01);
    wait_idle("t5_rlast");
    // 5b: RRESP 01 on beat 3
    cfg_rlast_beat = -1; cfg_rresp_beat = 2; cfg_rresp_val = 2'b01; cfg_r_base = 32'h80;
    exp_ar_q.push_back(pack_ax(32'h400, 8'd3, 2'b01, 3'd2));
    for (int i = 0; i < 4; i++) exp_rd_q.push_back(pack_rd(i == 3, 32'h80 + 32'(i)));
    exp_done_q.push_back(pack_done(2'b01, 1'b0));
    send_cmd(1'b0, 32'h400, 8'd3, 2'b01);
    wait_idle("t5_rresp");
    cfg_rresp_beat = -1;

    // 6: reset after 2 of 4 write beats; no done, then a normal write
    exp_aw_q.push_back(pack_ax(32'h500, 8'd3, 2'b01, 3'd2));
    wr_src_q.push_back(32'hD0);
    wr_src_q.push_back(32'hD1);
    exp_w_q.push_back(pack_w(4'hF, 1'b0, 32'hD0));
    exp_w_q.push_back(pack_w(4'hF, 1'b0, 32'hD1));
    send_cmd(1'b1, 32'h500, 8'd3, 2'b01);
    wait_idle("t6_two_beats");
    @(posedge aclk);
    #1;
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    check("t6_valids_after_reset", 64'({bus.awvalid, bus.arvalid, bus.wvalid, bus.bready,
                                        bus.rd_valid, bus.wr_ready, bus.done}), 64'd0);
    check("t6_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    repeat (5) @(negedge aclk);
    exp_aw_q.push_back(pack_ax(32'h600, 8'd1, 2'b01, 3'd2));
    wr_src_q.push_back(32'hE0);
    wr_src_q.push_back(32'hE1);
    exp_w_q.push_back(pack_w(4'hF, 1'b0, 32'hE0));
    exp_w_q.push_back(pack_w(4'hF, 1'b1, 32'hE1));
    exp_done_q.push_back(pack_done(2'b00, 1'b0));
    send_cmd(1'b1, 32'h600, 8'd1, 2'b01);
    wait_idle("t6_after");

    check("end_pending", 64'(exp_aw_q.size() + exp_ar_q.size() + exp_w_q.size()
                              + exp_rd_q.size() + exp_done_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
